// File: rtl/frame_blob_scanner_pkg.sv
// Camera-path shared definitions: frame geometry, counter widths, scanner FSM
// encodings and the blob result record. Shared with the capture and display blocks.
package frame_blob_scanner_pkg;

  localparam int IMG_W        = 96;
  localparam int IMG_H        = 96;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W       = 15;
  localparam int XY_W         = 7;
  localparam int CNT_W        = 14;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [XY_W-1:0]  x_min;
    logic [XY_W-1:0]  x_max;
    logic [XY_W-1:0]  y_min;
    logic [XY_W-1:0]  y_max;
  } bbox_t;

  // An empty frame reports an all-zero box instead of the min/max seed values.
  function automatic bbox_t box_or_zero(input bbox_t b);
    bbox_t r;
    r = b;
    if (b.count == '0) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/frame_blob_scanner_bbox_accumulator.sv
// Lit-pixel counter and bounding-box tracker. Clear seeds the minima with the
// far image corner and the maxima with zero so the first lit pixel sets both.
module frame_blob_scanner_bbox_accumulator
  import frame_blob_scanner_pkg::*;
(
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Clear,
  input  logic            i_Pix_Vld,
  input  logic            i_Lit,
  input  logic [XY_W-1:0] i_X,
  input  logic [XY_W-1:0] i_Y,
  output bbox_t           o_Box
);

  bbox_t r_box;

  // Accumulate count and extend the box for every valid lit pixel.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_box <= '0;
    end else if (i_Clear) begin
      r_box.count <= '0;
      r_box.x_min <= XY_W'(IMG_W - 1);
      r_box.x_max <= '0;
      r_box.y_min <= XY_W'(IMG_H - 1);
      r_box.y_max <= '0;
    end else if (i_Pix_Vld && i_Lit) begin
      r_box.count <= r_box.count + CNT_W'(1);
      if (i_X < r_box.x_min) r_box.x_min <= i_X;
      if (i_X > r_box.x_max) r_box.x_max <= i_X;
      if (i_Y < r_box.y_min) r_box.y_min <= i_Y;
      if (i_Y > r_box.y_max) r_box.y_max <= i_Y;
    end
  end

  assign o_Box = r_box;

endmodule

// File: rtl/frame_blob_scanner.sv
// Post-capture blob scanner: reads the whole frame buffer once in raster order,
// thresholds each byte and reports lit-pixel count and bounding box.
module frame_blob_scanner
  import frame_blob_scanner_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic [7:0]        i_Threshold,
  output logic [ADDR_W-1:0] o_RAM_Addr,
  input  logic [7:0]        i_RAM_Data,
  output logic              o_Busy,
  output logic              o_Valid,
  output logic              o_Found,
  output logic [CNT_W-1:0]  o_Count,
  output logic [XY_W-1:0]   o_X_Min,
  output logic [XY_W-1:0]   o_X_Max,
  output logic [XY_W-1:0]   o_Y_Min,
  output logic [XY_W-1:0]   o_Y_Max
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [XY_W-1:0]   r_x;
  logic [XY_W-1:0]   r_y;
  logic [1:0]        r_drain;
  logic [7:0]        r_thr;
  logic              r_vld_p [RAM_LAT];
  logic [XY_W-1:0]   r_x_p   [RAM_LAT];
  logic [XY_W-1:0]   r_y_p   [RAM_LAT];
  bbox_t             r_hold;
  bbox_t             w_acc;
  bbox_t             w_res;
  logic              w_accept;
  logic              w_lit;

  assign w_accept = (r_state == ST_IDLE) && i_Start;

  // Scan sequencer: raster address plus x/y counters, then wait out RAM latency.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_Start) begin
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_addr == ADDR_W'(FRAME_PIXELS - 1)) begin
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == XY_W'(IMG_W - 1)) begin
              r_x <= '0;
              r_y <= r_y + XY_W'(1);
            end else begin
              r_x <= r_x + XY_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain == 2'(RAM_LAT - 1)) r_state <= ST_DONE;
          else                            r_drain <= r_drain + 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid flag travels with each issued address so returning data is tagged.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < RAM_LAT; i++) r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= (r_state == ST_SCAN);
      for (int i = 1; i < RAM_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Coordinate delay line matched to RAM latency; threshold captured at start.
  always_ff @(posedge i_Clk) begin
    r_x_p[0] <= r_x;
    r_y_p[0] <= r_y;
    for (int i = 1; i < RAM_LAT; i++) begin
      r_x_p[i] <= r_x_p[i-1];
      r_y_p[i] <= r_y_p[i-1];
    end
    if (w_accept) r_thr <= i_Threshold;
  end

  assign w_lit = (i_RAM_Data >= r_thr);

  frame_blob_scanner_bbox_accumulator u_acc (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Clear   (w_accept),
    .i_Pix_Vld (r_vld_p[RAM_LAT-1]),
    .i_Lit     (w_lit),
    .i_X       (r_x_p[RAM_LAT-1]),
    .i_Y       (r_y_p[RAM_LAT-1]),
    .o_Box     (w_acc)
  );

  // Result holding register; the accumulator feeds the outputs directly during
  // DONE because its last pixel lands on the same edge that enters DONE.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                r_hold <= '0;
    else if (r_state == ST_DONE) r_hold <= box_or_zero(w_acc);
  end

  assign w_res      = (r_state == ST_DONE) ? box_or_zero(w_acc) : r_hold;
  assign o_Count    = w_res.count;
  assign o_X_Min    = w_res.x_min;
  assign o_X_Max    = w_res.x_max;
  assign o_Y_Min    = w_res.y_min;
  assign o_Y_Max    = w_res.y_max;
  assign o_Found    = (w_res.count != '0);
  assign o_Valid    = (r_state == ST_DONE);
  assign o_Busy     = (r_state != ST_IDLE);
  assign o_RAM_Addr = (r_state == ST_SCAN) ? r_addr : '0;

endmodule

// File: tb/tb_frame_blob_scanner.sv
// Bench for frame_blob_scanner: two instances (RAM_LAT 1 and 2) each with its
// own behavioural frame RAM, driven in parallel by the same test sequence.
module tb_frame_blob_scanner;
  import frame_blob_scanner_pkg::*;

  localparam int N        = FRAME_PIXELS;
  localparam int K_ZERO   = 0;
  localparam int K_SINGLE = 1;
  localparam int K_BLOCK  = 2;
  localparam int K_RAND   = 3;
  localparam int K_TWO255 = 4;

  typedef struct {
    int         kind;
    logic [7:0] thr;
    int         found;
    int         cnt;
    int         xmin;
    int         xmax;
    int         ymin;
    int         ymax;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n [2];
  logic              start [2];
  logic [7:0]        thr   [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [7:0]        rdata [2];
  logic              busy  [2];
  logic              valid [2];
  logic              found [2];
  logic [CNT_W-1:0]  count [2];
  logic [XY_W-1:0]   xmin  [2];
  logic [XY_W-1:0]   xmax  [2];
  logic [XY_W-1:0]   ymin  [2];
  logic [XY_W-1:0]   ymax  [2];
  logic [7:0]        mem   [2][N];
  vec_t              vecs  [4];
  int                n_checks = 0;
  int                n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [7:0] rd_q [g+1];

    always @(posedge clk) begin
      rd_q[0] <= mem[g][addr[g]];
      for (int i = 1; i <= g; i++) rd_q[i] <= rd_q[i-1];
    end
    assign rdata[g] = rd_q[g];

    frame_blob_scanner #(.RAM_LAT(g + 1)) u_dut (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n[g]),
      .i_Start     (start[g]),
      .i_Threshold (thr[g]),
      .o_RAM_Addr  (addr[g]),
      .i_RAM_Data  (rdata[g]),
      .o_Busy      (busy[g]),
      .o_Valid     (valid[g]),
      .o_Found     (found[g]),
      .o_Count     (count[g]),
      .o_X_Min     (xmin[g]),
      .o_X_Max     (xmax[g]),
      .o_Y_Min     (ymin[g]),
      .o_Y_Max     (ymax[g])
    );
  end

  task automatic chk(input int d, input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL lat%0d %s: got %0d, expected %0d", d + 1, nm, act, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string nm);
    chk(d, {nm, ".busy"},  int'(busy[d]),  0);
    chk(d, {nm, ".valid"}, int'(valid[d]), 0);
    chk(d, {nm, ".found"}, int'(found[d]), 0);
    chk(d, {nm, ".count"}, int'(count[d]), 0);
    chk(d, {nm, ".box"},   int'({xmin[d], xmax[d], ymin[d], ymax[d]}), 0);
    chk(d, {nm, ".addr"},  int'(addr[d]),  0);
  endtask

  task automatic fill_frame(input int d, input int kind);
    for (int a = 0; a < N; a++) begin
      case (kind)
        K_ZERO:   mem[d][a] = 8'd0;
        K_SINGLE: mem[d][a] = 8'($urandom_range(127, 0));
        K_BLOCK:  mem[d][a] = 8'($urandom_range(99, 0));
        K_RAND:   mem[d][a] = 8'($urandom_range(255, 0));
        default:  mem[d][a] = 8'($urandom_range(254, 0));
      endcase
    end
    case (kind)
      K_SINGLE: mem[d][20*96 + 10] = 8'd200;
      K_BLOCK: begin
        for (int y = 0; y < 4; y++)
          for (int x = 93; x < 96; x++) mem[d][y*96 + x] = 8'd255;
        mem[d][9215] = 8'd100;
      end
      K_TWO255: begin
        mem[d][5*96 + 20]  = 8'd255;
        mem[d][72*96 + 88] = 8'd255;
      end
      default: ;
    endcase
  endtask

  // Starts a scan from IDLE at a negedge and follows it to one cycle past DONE.
  task automatic run_scan(input int d, input string nm, input logic [7:0] t,
                          input bit extra, input vec_t e);
    int done_j = N + d + 2;
    int nvalid = 0;
    int seen_j = -1;
    int c_found = -1, c_cnt = -1, c_box = -1;
    thr[d]   = t;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk(d, {nm, ".busy_k1"}, int'(busy[d]), 1);
    for (int j = 1; j <= done_j + 1; j++) begin
      if (valid[d]) begin
        nvalid++;
        if (seen_j < 0) begin
          seen_j  = j;
          c_found = int'(found[d]);
          c_cnt   = int'(count[d]);
          c_box   = int'({xmin[d], xmax[d], ymin[d], ymax[d]});
        end
      end
      if (j == 1)          chk(d, {nm, ".addr_first"}, int'(addr[d]), 0);
      if (j == 98)         chk(d, {nm, ".addr_wrap"},  int'(addr[d]), 97);
      if (j == N)          chk(d, {nm, ".addr_last"},  int'(addr[d]), N - 1);
      if (j == N + 1)      chk(d, {nm, ".addr_drain"}, int'(addr[d]), 0);
      if (j == done_j)     chk(d, {nm, ".busy_done"},  int'(busy[d]), 1);
      if (j == done_j + 1) chk(d, {nm, ".busy_after"}, int'(busy[d]), 0);
      start[d] = extra && (j == 100 || j == done_j);
      if (j <= done_j) @(negedge clk);
    end
    start[d] = 1'b0;
    chk(d, {nm, ".valid_cycle"}, seen_j, done_j);
    chk(d, {nm, ".valid_pulses"}, nvalid, 1);
    chk(d, {nm, ".found"}, c_found, e.found);
    chk(d, {nm, ".count"}, c_cnt, e.cnt);
    chk(d, {nm, ".box"}, c_box, (e.xmin << 21) | (e.xmax << 14) | (e.ymin << 7) | e.ymax);
    chk(d, {nm, ".hold_count"}, int'(count[d]), e.cnt);
    chk(d, {nm, ".hold_xmin"},  int'(xmin[d]),  e.xmin);
  endtask

  task automatic run_all(input int d);
    vec_t e_single = '{K_SINGLE, 8'd128, 1, 1, 10, 10, 20, 20};
    int   nv = 0;
    rst_n[d] = 1'b0;
    start[d] = 1'b0;
    thr[d]   = 8'd0;
    repeat (3) @(negedge clk);
    chk_idle(d, "reset");
    rst_n[d] = 1'b1;
    @(negedge clk);
    chk_idle(d, "post_reset");

    for (int i = 0; i < 4; i++) begin
      fill_frame(d, vecs[i].kind);
      run_scan(d, $sformatf("vec%0d", i), vecs[i].thr, 1'b0, vecs[i]);
    end

    // Extra starts mid-scan and in DONE must be ignored.
    fill_frame(d, K_SINGLE);
    run_scan(d, "ignore_start", 8'd128, 1'b1, e_single);

    // Start one cycle after DONE is accepted, then reset lands mid-scan.
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk(d, "restart.busy", int'(busy[d]), 1);
    for (int j = 2; j <= 5000; j++) @(negedge clk);
    chk(d, "restart.addr_k5000", int'(addr[d]), 4999);
    rst_n[d] = 1'b0;
    #1;
    chk_idle(d, "midscan_rst");
    repeat (2) begin
      @(negedge clk);
      if (valid[d]) nv++;
    end
    chk(d, "midscan_rst.no_valid", nv, 0);
    rst_n[d] = 1'b1;
    fill_frame(d, K_BLOCK);
    @(negedge clk);
    chk_idle(d, "after_rst");
    run_scan(d, "after_rst_scan", 8'd100, 1'b0, vecs[1]);
  endtask

  initial begin
    vecs[0] = '{K_ZERO,   8'd1,   0, 0,    0,  0,  0,  0};
    vecs[1] = '{K_BLOCK,  8'd100, 1, 13,   93, 95, 0,  95};
    vecs[2] = '{K_RAND,   8'd0,   1, 9216, 0,  95, 0,  95};
    vecs[3] = '{K_TWO255, 8'd255, 1, 2,    20, 88, 5,  72};
    fork
      run_all(0);
      run_all(1);
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
